// File: rtl/gray_pixel_packer.sv
`default_nettype none
// ============================================================================
// gray_pixel_packer
// Packs four 8-bit grayscale pixels per little-endian 32-bit word and buffers
// the words in a show-ahead FIFO drained over a valid/ready handshake.
// Revision: 1.0
// ============================================================================
module gray_pixel_packer #(
   parameter int FIFO_DEPTH = 8,
   parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clock,
   input  logic               nReset,
   input  logic               frameStart,
   input  logic               pixelValid,
   input  logic [7:0]         grayPixel,
   output logic               wordValid,
   output logic [31:0]        wordData,
   input  logic               wordReady,
   output logic [LEVEL_W-1:0] fifoLevel,
   output logic               overflow,
   input  logic               clearOverflow
);

   localparam int                 PTR_W      = LEVEL_W - 1;
   localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);
   localparam logic [1:0]         LAST_BYTE  = 2'd3;

   // ------------------------------------------------------------------
   // Packing stage
   // ------------------------------------------------------------------
   logic [1:0]  byte_idx;
   logic [1:0]  eff_idx;
   logic [23:0] partial;
   logic        push_req;
   logic [31:0] push_word;

   // A frame start realigns packing so the pixel in the same cycle is byte 0.
   always_comb begin
      eff_idx   = frameStart ? 2'd0 : byte_idx;
      push_req  = pixelValid && (eff_idx == LAST_BYTE);
      push_word = {grayPixel, partial};
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         byte_idx <= 2'd0;
         partial  <= 24'd0;
      end else if (pixelValid) begin
         byte_idx <= eff_idx + 2'd1;
         case (eff_idx)
            2'd0:    partial[7:0]   <= grayPixel;
            2'd1:    partial[15:8]  <= grayPixel;
            2'd2:    partial[23:16] <= grayPixel;
            default: partial        <= partial;
         endcase
      end else if (frameStart) begin
         byte_idx <= 2'd0;
      end
   end

   // ------------------------------------------------------------------
   // Word FIFO
   // ------------------------------------------------------------------
   logic [31:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LEVEL_W-1:0] level;
   logic               full;
   logic               pop;
   logic               push_ok;
   logic               drop;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   always_comb begin
      full    = (level == FULL_LEVEL);
      pop     = (level != '0) && wordReady;
      push_ok = push_req && (!full || pop);
      drop    = push_req && full && !pop;
   end

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_word;
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push_ok) begin
            level <= level - 1'b1;
         end
      end
   end

   // Setting on a dropped word takes priority over a simultaneous clear.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clearOverflow) begin
         overflow <= 1'b0;
      end
   end

   assign wordValid = (level != '0);
   assign wordData  = mem[rd_ptr];
   assign fifoLevel = level;

endmodule
`default_nettype wire

// File: tb/tb_gray_pixel_packer.sv
`default_nettype none
// Directed self-checking bench for gray_pixel_packer.
module tb_gray_pixel_packer;

   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          nReset = 1'b0;
   logic          frameStart = 1'b0;
   logic          pixelValid = 1'b0;
   logic [7:0]    grayPixel = 8'h00;
   logic          wordValid;
   logic [31:0]   wordData;
   logic          wordReady = 1'b0;
   logic [LW-1:0] fifoLevel;
   logic          overflow;
   logic          clearOverflow = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   gray_pixel_packer #(.FIFO_DEPTH(DEPTH)) dut (
      .clock         (clock),
      .nReset        (nReset),
      .frameStart    (frameStart),
      .pixelValid    (pixelValid),
      .grayPixel     (grayPixel),
      .wordValid     (wordValid),
      .wordData      (wordData),
      .wordReady     (wordReady),
      .fifoLevel     (fifoLevel),
      .overflow      (overflow),
      .clearOverflow (clearOverflow)
   );

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_pixel(input logic [7:0] p);
      pixelValid = 1'b1;
      grayPixel  = p;
      step();
      pixelValid = 1'b0;
   endtask

   function automatic logic [31:0] mk_word(input int w);
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(16 * w + 0);
      b1 = 8'(16 * w + 1);
      b2 = 8'(16 * w + 2);
      b3 = 8'(16 * w + 3);
      return {b3, b2, b1, b0};
   endfunction

   task automatic send_word(input int w);
      for (int b = 0; b < 4; b++) send_pixel(8'(16 * w + b));
   endtask

   task automatic do_reset();
      nReset = 1'b0;
      wordReady = 1'b0;
      pixelValid = 1'b0;
      frameStart = 1'b0;
      clearOverflow = 1'b0;
      step();
      step();
      nReset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      nReset = 1'b0;
      step();
      checks++;
      if (wordValid !== 1'b0) begin
         errors++; $display("FAIL reset_wordValid: got %b expected 0", wordValid);
      end
      checks++;
      if (fifoLevel !== '0) begin
         errors++; $display("FAIL reset_level: got %0d expected 0", fifoLevel);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL reset_overflow: got %b expected 0", overflow);
      end
      nReset = 1'b1;
      step();
   endtask

   task automatic test_basic_pack();
      wordReady = 1'b0;
      send_pixel(8'h11);
      send_pixel(8'h22);
      send_pixel(8'h33);
      checks++;
      if (wordValid !== 1'b0) begin
         errors++; $display("FAIL basic_early_valid: got %b expected 0", wordValid);
      end
      send_pixel(8'h44);
      checks++;
      if (wordValid !== 1'b1) begin
         errors++; $display("FAIL basic_valid: got %b expected 1", wordValid);
      end
      checks++;
      if (wordData !== 32'h44332211) begin
         errors++; $display("FAIL basic_data: got %h expected 44332211", wordData);
      end
      checks++;
      if (fifoLevel !== LW'(1)) begin
         errors++; $display("FAIL basic_level: got %0d expected 1", fifoLevel);
      end
      wordReady = 1'b1;
      step();
      wordReady = 1'b0;
      checks++;
      if (wordValid !== 1'b0 || fifoLevel !== '0) begin
         errors++; $display("FAIL basic_pop: got valid %b level %0d expected 0/0", wordValid, fifoLevel);
      end
   endtask

   task automatic test_frame_realign();
      send_pixel(8'hAA);
      send_pixel(8'hBB);
      frameStart = 1'b1;
      send_pixel(8'h01);
      frameStart = 1'b0;
      send_pixel(8'h02);
      send_pixel(8'h03);
      checks++;
      if (fifoLevel !== '0) begin
         errors++; $display("FAIL realign_no_stale_word: got level %0d expected 0", fifoLevel);
      end
      send_pixel(8'h04);
      checks++;
      if (fifoLevel !== LW'(1)) begin
         errors++; $display("FAIL realign_level: got %0d expected 1", fifoLevel);
      end
      checks++;
      if (wordData !== 32'h04030201) begin
         errors++; $display("FAIL realign_data: got %h expected 04030201", wordData);
      end
      wordReady = 1'b1;
      step();
      wordReady = 1'b0;
      checks++;
      if (fifoLevel !== '0) begin
         errors++; $display("FAIL realign_single_word: got level %0d expected 0", fifoLevel);
      end
   endtask

   task automatic test_gapped();
      logic [31:0] exp_words [2];
      int seen;
      exp_words[0] = 32'h13121110;
      exp_words[1] = 32'h17161514;
      seen = 0;
      wordReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         for (int s = 0; s < 3; s++) begin
            pixelValid = (s == 0);
            grayPixel  = 8'(8'h10 + i);
            step();
            pixelValid = 1'b0;
            checks++;
            if (fifoLevel > LW'(1)) begin
               errors++; $display("FAIL gapped_level: got %0d expected <=1", fifoLevel);
            end
            if (wordValid === 1'b1) begin
               checks++;
               if (seen > 1 || wordData !== exp_words[seen > 1 ? 1 : seen]) begin
                  errors++; $display("FAIL gapped_word%0d: got %h", seen, wordData);
               end
               seen++;
            end
         end
      end
      checks++;
      if (seen != 2) begin
         errors++; $display("FAIL gapped_count: got %0d words expected 2", seen);
      end
      wordReady = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int w = 0; w < DEPTH + 1; w++) send_word(w);
      checks++;
      if (fifoLevel !== LW'(DEPTH)) begin
         errors++; $display("FAIL ovf_level: got %0d expected %0d", fifoLevel, DEPTH);
      end
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_flag: got %b expected 1", overflow);
      end
      wordReady = 1'b1;
      for (int w = 0; w < DEPTH; w++) begin
         checks++;
         if (wordValid !== 1'b1 || wordData !== mk_word(w)) begin
            errors++; $display("FAIL ovf_drain%0d: got valid %b data %h expected %h", w, wordValid, wordData, mk_word(w));
         end
         step();
      end
      wordReady = 1'b0;
      checks++;
      if (wordValid !== 1'b0) begin
         errors++; $display("FAIL ovf_ninth_absent: got valid %b data %h expected empty", wordValid, wordData);
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int w = 0; w < DEPTH; w++) send_word(w);
      for (int b = 0; b < 3; b++) send_pixel(8'(16 * DEPTH + b));
      wordReady = 1'b1;
      send_pixel(8'(16 * DEPTH + 3));
      wordReady = 1'b0;
      checks++;
      if (fifoLevel !== LW'(DEPTH)) begin
         errors++; $display("FAIL fullpp_level: got %0d expected %0d", fifoLevel, DEPTH);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL fullpp_overflow: got %b expected 0", overflow);
      end
      wordReady = 1'b1;
      for (int w = 1; w <= DEPTH; w++) begin
         checks++;
         if (wordValid !== 1'b1 || wordData !== mk_word(w)) begin
            errors++; $display("FAIL fullpp_drain%0d: got valid %b data %h expected %h", w, wordValid, wordData, mk_word(w));
         end
         step();
      end
      wordReady = 1'b0;
      checks++;
      if (wordValid !== 1'b0) begin
         errors++; $display("FAIL fullpp_empty: got valid %b expected 0", wordValid);
      end
   endtask

   task automatic test_overflow_clear();
      do_reset();
      for (int w = 0; w < DEPTH; w++) send_word(w);
      for (int b = 0; b < 3; b++) send_pixel(8'(16 * DEPTH + b));
      clearOverflow = 1'b1;
      send_pixel(8'(16 * DEPTH + 3));
      clearOverflow = 1'b0;
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL clr_set_wins: got %b expected 1", overflow);
      end
      step();
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL clr_sticky: got %b expected 1", overflow);
      end
      clearOverflow = 1'b1;
      step();
      clearOverflow = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL clr_lone: got %b expected 0", overflow);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int w = 0; w < DEPTH + 1; w++) send_word(w);
      send_pixel(8'hE0);
      send_pixel(8'hE1);
      #2;
      nReset = 1'b0;
      #1;
      checks++;
      if (wordValid !== 1'b0 || fifoLevel !== '0 || overflow !== 1'b0) begin
         errors++; $display("FAIL async_reset: got valid %b level %0d ovf %b expected 0/0/0", wordValid, fifoLevel, overflow);
      end
      step();
      nReset = 1'b1;
      step();
      send_pixel(8'h55);
      send_pixel(8'h66);
      send_pixel(8'h77);
      send_pixel(8'h88);
      checks++;
      if (fifoLevel !== LW'(1) || wordData !== 32'h88776655) begin
         errors++; $display("FAIL async_realign: got level %0d data %h expected 1/88776655", fifoLevel, wordData);
      end
   endtask

   initial begin
      test_reset();
      test_basic_pack();
      test_frame_realign();
      test_gapped();
      test_overflow();
      test_full_push_pop();
      test_overflow_clear();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gray_pixel_packer.md
# gray_pixel_packer

Downstream stage of the RGB565-to-grayscale converter. Collects one 8-bit grayscale pixel per valid cycle and packs four consecutive pixels into a 32-bit little-endian word. Buffers packed words in a small show-ahead FIFO and presents them to the frame-buffer/DMA writer over a valid/ready handshake. Reports FIFO occupancy and a sticky overflow flag.

## Interface
Parameters:
- FIFO_DEPTH, 8: number of 32-bit words buffered; power of two, at least 2.
- LEVEL_W, $clog2(FIFO_DEPTH)+1: width of `fifoLevel`; derived, not overridden.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- nReset  in  1  reset, asynchronous and active-low.
- frameStart  in  1  one-cycle pulse at start of frame; realigns packing.
- pixelValid  in  1  `grayPixel` carries a pixel this cycle.
- grayPixel  in  8  grayscale pixel from the converter.
- wordValid  out  1  FIFO head holds a word (`fifoLevel` != 0).
- wordData  out  32  FIFO head word; stable while `wordValid` is high and not popped.
- wordReady  in  1  consumer accepts the head word when `wordValid` is also high.
- fifoLevel  out  LEVEL_W  words currently stored, 0..FIFO_DEPTH.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- clearOverflow  in  1  clears `overflow`.

## Operation
- Packing: a 2-bit byte index `idx` and a 24-bit partial register hold bytes 0..2.
- On `pixelValid`, the pixel becomes byte `idx` of the current word (bits 8*idx+7 : 8*idx), and `idx` increments modulo 4.
- When `pixelValid` is high and `idx`==3, the completed word {grayPixel, partial[23:0]} is pushed in the same edge. `idx` wraps to 0.
- `frameStart` forces `idx` to 0 and discards any partial bytes; no padded word is emitted.
- `frameStart` and `pixelValid` in the same cycle: the pixel is byte 0 of a new word, and `idx` becomes 1.
- FIFO: circular buffer with read/write pointers of LEVEL_W-1 bits, wrapping naturally, plus a level counter.
  - `wordData` = mem[rdPtr] (show-ahead).
  - Pop when `wordValid` && `wordReady`.
  - Push and pop in the same cycle: both are performed and the level is unchanged. This also holds when the FIFO is full, because the pop frees the slot.
  - Push while full with no pop: the word is dropped, pointers and level are unchanged, and `overflow` is set.
  - Pop while empty: impossible, since `wordValid`=0.
- Overflow: set on a dropped push; cleared by `clearOverflow`. Set wins over clear in the same cycle.
- Pixels never stall. The block has no backpressure toward the converter.

## Timing
- Reset (asynchronous assert, synchronous release) gives:
  - `wordValid`=0, `fifoLevel`=0, `overflow`=0.
  - `idx`=0, pointers=0.
  - `wordData` is don't-care while `wordValid`=0. Memory contents are not reset.
- Reset asserted mid-frame or mid-word discards all partial and buffered data immediately.
- Latency: if the 4th pixel of a word arrives in cycle n and the FIFO was empty, then `wordValid`=1 and `wordData`=word in cycle n+1.
- Throughput: at most one push per 4 valid pixels, and one pop per cycle.
- `fifoLevel` updates on the same edge as the push or pop.
- `overflow` rises one cycle after the dropped-push cycle.

## Test plan
- Reset, then pixels 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `wordReady`=0: the cycle after 0x44 shows `wordValid`=1, `wordData`=0x44332211, `fifoLevel`=1.
- Pixels 0xAA, 0xBB, then `frameStart` together with pixel 0x01, followed by 0x02, 0x03, 0x04: exactly one word, 0x04030201, and no word containing 0xAA/0xBB.
- Gapped pixels (`pixelValid` every third cycle) with values 0x10..0x17 and `wordReady`=1: words 0x13121110 then 0x17161514 appear in order, each popped the cycle it appears; `fifoLevel` never exceeds 1.
- Hold `wordReady`=0 and push FIFO_DEPTH+1 words: `fifoLevel`=8 and `overflow`=1. Draining yields the first 8 words in order; the 9th is absent.
- With the FIFO full, complete a word in the same cycle `wordReady`=1: the head is popped, the new word is accepted, `fifoLevel` stays 8, and `overflow` stays 0.
- `clearOverflow` in the same cycle as a dropped push: `overflow` stays 1. A later lone `clearOverflow` takes it to 0. Asserting `nReset` low mid-word asynchronously forces all outputs to their reset values.
